// File: rtl/wb_pkg.sv
// Shared write-back definitions: W control bit positions, register-zero index and datapath types.
// Used by wb_regfile, the MEM/WB register and the forwarding unit.
package wb_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int W_REGWRITE = 1;
    localparam int W_MEMTOREG = 0;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/wb_regfile_if.sv
// Bus between the MEM/WB + ID stages (master side) and the write-back/register-file block (slave side).
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [1:0]        W_in;
    logic [DATA_W-1:0] RD_in;
    logic [DATA_W-1:0] ADDR_in;
    logic [ADDR_W-1:0] WN_in;
    logic [ADDR_W-1:0] RN1;
    logic [ADDR_W-1:0] RN2;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic [DATA_W-1:0] WD_out;
    logic              WE_out;

    modport master (
        output W_in, RD_in, ADDR_in, WN_in, RN1, RN2,
        input  RD1, RD2, WD_out, WE_out
    );

    modport slave (
        input  W_in, RD_in, ADDR_in, WN_in, RN1, RN2,
        output RD1, RD2, WD_out, WE_out
    );
endinterface

// File: rtl/wb_select.sv
// Write-back data mux and effective write-enable qualification (purely combinational).
module wb_select
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [1:0]        w,
    input  logic [DATA_W-1:0] rd,
    input  logic [DATA_W-1:0] addr,
    input  logic [ADDR_W-1:0] wn,
    output logic [DATA_W-1:0] wd,
    output logic              we
);

    assign wd = w[W_MEMTOREG] ? rd : addr;
    // Register 0 is hardwired, so a write aimed at it is not a write at all.
    assign we = w[W_REGWRITE] & (wn != ADDR_W'(REG_ZERO));

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus 32x32 architectural register file with write-through read bypass.
// Optional debug port and commit counter enabled by defining WB_REGFILE_DBG_EN.
module wb_regfile
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    wb_regfile_if.slave       bus
`ifdef WB_REGFILE_DBG_EN
    ,
    input  logic [ADDR_W-1:0] dbg_rn,
    output logic [DATA_W-1:0] dbg_rd,
    output logic [31:0]       wb_count
`endif
);

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] wd;
    logic              we;

    wb_select #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_wb_select (
        .w    (bus.W_in),
        .rd   (bus.RD_in),
        .addr (bus.ADDR_in),
        .wn   (bus.WN_in),
        .wd   (wd),
        .we   (we)
    );

    assign bus.WD_out = wd;
    assign bus.WE_out = we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we) begin
            regs[bus.WN_in] <= wd;
        end
    end

    // Bypass is evaluated on live inputs, so it also holds while the array is held in reset.
    always_comb begin
        bus.RD1 = '0;
        if (bus.RN1 == ADDR_W'(REG_ZERO))      bus.RD1 = '0;
        else if (we && bus.RN1 == bus.WN_in)   bus.RD1 = wd;
        else                                   bus.RD1 = regs[bus.RN1];
    end

    always_comb begin
        bus.RD2 = '0;
        if (bus.RN2 == ADDR_W'(REG_ZERO))      bus.RD2 = '0;
        else if (we && bus.RN2 == bus.WN_in)   bus.RD2 = wd;
        else                                   bus.RD2 = regs[bus.RN2];
    end

`ifdef WB_REGFILE_DBG_EN
    assign dbg_rd = regs[dbg_rn];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    wb_count <= '0;
        else if (we) wb_count <= wb_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile: reset, write/read, load select, bypass, register zero, bubbles.
module tb_wb_regfile;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nvec = 0;
    int   nmis = 0;

    wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

`ifdef WB_REGFILE_DBG_EN
    logic [4:0]  dbg_rn = '0;
    logic [31:0] dbg_rd;
    logic [31:0] wb_count;
`endif

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave)
`ifdef WB_REGFILE_DBG_EN
        ,
        .dbg_rn   (dbg_rn),
        .dbg_rd   (dbg_rd),
        .wb_count (wb_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Drive a bus setting at the falling edge, outputs settle 1 time unit later.
    task automatic drive(input logic [1:0] w, input logic [31:0] rd, input logic [31:0] addr,
                         input logic [4:0] wn, input logic [4:0] rn1, input logic [4:0] rn2);
        @(negedge clk);
        bus.W_in = w; bus.RD_in = rd; bus.ADDR_in = addr; bus.WN_in = wn;
        bus.RN1 = rn1; bus.RN2 = rn2;
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] val);
        drive(2'b10, 32'h0, val, idx, 5'd0, 5'd0);
    endtask

    initial begin
        bus.W_in = 2'b00; bus.RD_in = '0; bus.ADDR_in = '0; bus.WN_in = '0;
        bus.RN1 = '0; bus.RN2 = '0;

        // Power-on reset: array reads zero, mux stays live.
        drive(2'b01, 32'hA5A5_0001, 32'h0000_0002, 5'd6, 5'd6, 5'd31);
        check("por_rd1", bus.RD1, 32'h0);
        check("por_rd2", bus.RD2, 32'h0);
        check("por_wd", bus.WD_out, 32'hA5A5_0001);
        check("por_we", {31'b0, bus.WE_out}, 32'h0);
        @(negedge clk); #2 rst = 1'b1;

        // Write then read.
        wr(5'd5, 32'h0000_1234);
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
        check("wr_rd1", bus.RD1, 32'h0000_1234);
        check("wr_rd2", bus.RD2, 32'h0000_1234);

        // Load select.
        drive(2'b11, 32'hDEAD_BEEF, 32'h0000_0001, 5'd9, 5'd0, 5'd0);
        check("ld_wd", bus.WD_out, 32'hDEAD_BEEF);
        check("ld_we", {31'b0, bus.WE_out}, 32'h1);
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);
        check("ld_rd1", bus.RD1, 32'hDEAD_BEEF);
        check("ld_rd2_zero", bus.RD2, 32'h0);

        // Bypass on both ports, then independent ports.
        wr(5'd7, 32'h0000_0011);
        drive(2'b10, 32'h0, 32'h0000_0022, 5'd7, 5'd7, 5'd7);
        check("byp_rd1", bus.RD1, 32'h0000_0022);
        check("byp_rd2", bus.RD2, 32'h0000_0022);
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
        check("byp_post_rd1", bus.RD1, 32'h0000_0022);
        drive(2'b10, 32'h0, 32'h0000_0033, 5'd7, 5'd7, 5'd5);
        check("byp_mix_rd1", bus.RD1, 32'h0000_0033);
        check("byp_mix_rd2", bus.RD2, 32'h0000_1234);
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd7, 5'd9);
        check("byp_mix_post", bus.RD1, 32'h0000_0033);

        // Register zero: write discarded, no bypass.
        drive(2'b10, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        check("z_we", {31'b0, bus.WE_out}, 32'h0);
        check("z_rd1_pre", bus.RD1, 32'h0);
        check("z_wd", bus.WD_out, 32'hFFFF_FFFF);
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        check("z_rd1_post", bus.RD1, 32'h0);

        // Bubble: no commit, mux still reflects select.
        wr(5'd3, 32'h0000_0044);
        drive(2'b01, 32'h0000_0055, 32'h0000_0066, 5'd3, 5'd3, 5'd0);
        check("bub_wd", bus.WD_out, 32'h0000_0055);
        check("bub_we", {31'b0, bus.WE_out}, 32'h0);
        check("bub_rd1", bus.RD1, 32'h0000_0044);
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
        check("bub_post", bus.RD1, 32'h0000_0044);

`ifdef WB_REGFILE_DBG_EN
        // Commits so far: 5, 9, 7, 7, 7, 3 = 6.
        check("dbg_cnt", wb_count, 32'd6);
        dbg_rn = 5'd9; #1;
        check("dbg_rd9", dbg_rd, 32'hDEAD_BEEF);
        drive(2'b10, 32'h0, 32'h0000_0077, 5'd9, 5'd0, 5'd0);
        check("dbg_nobyp", dbg_rd, 32'hDEAD_BEEF);
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        check("dbg_cnt2", wb_count, 32'd7);
`endif

        // Mid-run async reset with stored values.
        @(negedge clk); #1 rst = 1'b0; #1;
        for (int i = 0; i < 32; i++) begin
            bus.RN1 = 5'(i); bus.RN2 = 5'(31 - i); #1;
            check($sformatf("rst_rd1_%0d", i), bus.RD1, 32'h0);
            check($sformatf("rst_rd2_%0d", i), bus.RD2, 32'h0);
        end
        drive(2'b10, 32'h0, 32'h0000_00AA, 5'd4, 5'd4, 5'd0);
        check("rst_byp", bus.RD1, 32'h0000_00AA);
        check("rst_we", {31'b0, bus.WE_out}, 32'h1);
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd4, 5'd5);
        check("rst_nocommit", bus.RD1, 32'h0);
        check("rst_r5", bus.RD2, 32'h0);
`ifdef WB_REGFILE_DBG_EN
        check("rst_cnt", wb_count, 32'd0);
`endif
        #2 rst = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0);
        check("rel_rd4", bus.RD1, 32'h0);
        wr(5'd4, 32'h0000_00BB);
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd4, 5'd7);
        check("rel_wr4", bus.RD1, 32'h0000_00BB);
        check("rel_r7", bus.RD2, 32'h0);
`ifdef WB_REGFILE_DBG_EN
        check("rel_cnt", wb_count, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
